// File: rtl/rate_scheduler.sv
// Shared DSP rate scheduler: global 32 kHz sample counter plus one time-shared
// "does rate N fire this sample" evaluator serving the noise LFSR and envelope voices.
module rate_scheduler #(
  parameter int VOICES    = 8,
  parameter int CTR_RANGE = 30720
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_en,
  input  logic                  exe_32khz,
  input  logic [4:0]            noise_rate_id,
  output logic                  noise_tick,
  input  logic [VOICES-1:0]     env_req,
  input  logic [5*VOICES-1:0]   env_rate_id,
  output logic [VOICES-1:0]     env_ack,
  output logic                  env_fire,
  output logic [14:0]           glob_ctr
);

  localparam int          PTR_W      = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [14:0] CTR_RELOAD = 15'(CTR_RANGE - 1);

  // Odd factor of each period; the rest of the period is a power of two.
  localparam logic [1:0] ODD_NEVER = 2'd0;
  localparam logic [1:0] ODD_1     = 2'd1;
  localparam logic [1:0] ODD_3     = 2'd2;
  localparam logic [1:0] ODD_5     = 2'd3;

  // period = odd * 2^k; the offset is tied to the odd factor (x3 -> 1040, x5 -> 536).
  function automatic logic rate_fires(input logic [14:0] ctr, input logic [4:0] rid);
    logic [3:0]  k;
    logic [1:0]  odd;
    logic [14:0] offset;
    logic [14:0] sum;
    logic [14:0] low_mask;
    logic [14:0] hi;
    logic        odd_ok;
    case (rid)
      5'd1:    {k, odd} = {4'd11, ODD_1};
      5'd2:    {k, odd} = {4'd9,  ODD_3};
      5'd3:    {k, odd} = {4'd8,  ODD_5};
      5'd4:    {k, odd} = {4'd10, ODD_1};
      5'd5:    {k, odd} = {4'd8,  ODD_3};
      5'd6:    {k, odd} = {4'd7,  ODD_5};
      5'd7:    {k, odd} = {4'd9,  ODD_1};
      5'd8:    {k, odd} = {4'd7,  ODD_3};
      5'd9:    {k, odd} = {4'd6,  ODD_5};
      5'd10:   {k, odd} = {4'd8,  ODD_1};
      5'd11:   {k, odd} = {4'd6,  ODD_3};
      5'd12:   {k, odd} = {4'd5,  ODD_5};
      5'd13:   {k, odd} = {4'd7,  ODD_1};
      5'd14:   {k, odd} = {4'd5,  ODD_3};
      5'd15:   {k, odd} = {4'd4,  ODD_5};
      5'd16:   {k, odd} = {4'd6,  ODD_1};
      5'd17:   {k, odd} = {4'd4,  ODD_3};
      5'd18:   {k, odd} = {4'd3,  ODD_5};
      5'd19:   {k, odd} = {4'd5,  ODD_1};
      5'd20:   {k, odd} = {4'd3,  ODD_3};
      5'd21:   {k, odd} = {4'd2,  ODD_5};
      5'd22:   {k, odd} = {4'd4,  ODD_1};
      5'd23:   {k, odd} = {4'd2,  ODD_3};
      5'd24:   {k, odd} = {4'd1,  ODD_5};
      5'd25:   {k, odd} = {4'd3,  ODD_1};
      5'd26:   {k, odd} = {4'd1,  ODD_3};
      5'd27:   {k, odd} = {4'd0,  ODD_5};
      5'd28:   {k, odd} = {4'd2,  ODD_1};
      5'd29:   {k, odd} = {4'd0,  ODD_3};
      5'd30:   {k, odd} = {4'd1,  ODD_1};
      5'd31:   {k, odd} = {4'd0,  ODD_1};
      default: {k, odd} = {4'd0,  ODD_NEVER};
    endcase
    case (odd)
      ODD_3:   offset = 15'd1040;
      ODD_5:   offset = 15'd536;
      default: offset = 15'd0;
    endcase
    sum      = ctr + offset;
    low_mask = (15'd1 << k) - 15'd1;
    hi       = sum >> k;
    case (odd)
      ODD_1:   odd_ok = 1'b1;
      ODD_3:   odd_ok = ((hi % 15'd3) == 15'd0);
      ODD_5:   odd_ok = ((hi % 15'd5) == 15'd0);
      default: odd_ok = 1'b0;
    endcase
    return odd_ok && ((sum & low_mask) == 15'd0);
  endfunction

  logic [14:0]       ctr_q, ctr_d;
  logic              pend_q, pend_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [VOICES-1:0] inflight_q, inflight_d;
  logic              tick_q, tick_d;
  logic [VOICES-1:0] ack_q, ack_d;
  logic              fire_q, fire_d;
  logic [VOICES-1:0] eligible;
  logic              grant_found;
  int                grant_idx;
  int                cand;

  // Slot selection: exe strobe > pending noise evaluation > envelope round-robin.
  always_comb begin
    ctr_d       = ctr_q;
    pend_d      = pend_q;
    rr_d        = rr_q;
    inflight_d  = inflight_q;
    tick_d      = 1'b0;
    ack_d       = '0;
    fire_d      = 1'b0;
    eligible    = env_req & ~inflight_q;
    grant_found = 1'b0;
    grant_idx   = 0;
    cand        = 0;
    for (int j = 0; j < VOICES; j++) begin
      cand = (int'(rr_q) + j) % VOICES;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end else begin
        grant_found = grant_found;
      end
    end
    if (cpu_en) begin
      if (exe_32khz) begin
        ctr_d  = (ctr_q == 15'd0) ? CTR_RELOAD : ctr_q - 15'd1;
        pend_d = 1'b1;
      end else if (pend_q) begin
        tick_d     = rate_fires(ctr_q, noise_rate_id);
        pend_d     = 1'b0;
        inflight_d = '0;
      end else if (grant_found) begin
        ack_d[grant_idx] = 1'b1;
        fire_d           = rate_fires(ctr_q, env_rate_id[5*grant_idx +: 5]);
        rr_d             = (grant_idx == VOICES - 1) ? '0 : PTR_W'(grant_idx + 1);
        inflight_d       = ack_d;
      end else begin
        inflight_d = '0;
      end
    end else begin
      ctr_d = ctr_q;
    end
  end

  // State and output registers; pulses drop back to zero on the following clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q      <= 15'd0;
      pend_q     <= 1'b0;
      rr_q       <= '0;
      inflight_q <= '0;
      tick_q     <= 1'b0;
      ack_q      <= '0;
      fire_q     <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      fire_q     <= fire_d;
    end
  end

  assign noise_tick = tick_q;
  assign env_ack    = ack_q;
  assign env_fire   = fire_q;
  assign glob_ctr   = ctr_q;

endmodule

// File: tb/tb_rate_scheduler.sv
// Self-checking bench for rate_scheduler: directed scenarios plus random traffic,
// every clk compared against a period/offset-table reference model.
module tb_rate_scheduler;

  localparam int V  = 8;
  localparam int CR = 30720;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cpu_en = 1'b0;
  logic             exe_32khz = 1'b0;
  logic [4:0]       noise_rate_id = 5'd0;
  logic             noise_tick;
  logic [V-1:0]     env_req = '0;
  logic [5*V-1:0]   env_rate_id = '0;
  logic [V-1:0]     env_ack;
  logic             env_fire;
  logic [14:0]      glob_ctr;

  always #5 clk = ~clk;

  rate_scheduler #(.VOICES(V), .CTR_RANGE(CR)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .exe_32khz(exe_32khz),
    .noise_rate_id(noise_rate_id), .noise_tick(noise_tick),
    .env_req(env_req), .env_rate_id(env_rate_id), .env_ack(env_ack),
    .env_fire(env_fire), .glob_ctr(glob_ctr)
  );

  int per_t [32] = '{0, 2048, 1536, 1280, 1024, 768, 640, 512, 384, 320, 256, 192, 160, 128,
                     96, 80, 64, 48, 40, 32, 24, 20, 16, 12, 10, 8, 6, 5, 4, 3, 2, 1};
  int off_t [32] = '{0, 0, 1040, 536, 0, 1040, 536, 0, 1040, 536, 0, 1040, 536, 0, 1040, 536,
                     0, 1040, 536, 0, 1040, 536, 0, 1040, 536, 0, 1040, 536, 0, 1040, 0, 0};

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_ctr, m_rr, m_last;
  bit  m_pend;
  int  n_exe, tick_cnt, t0;
  int  tick_strobe[$];
  int  tick_ctr[$];
  int  ack_order[$];
  bit  ack_fire[$];
  bit  rnd_req = 1'b0;

  function automatic bit mfire(int c, int r);
    if (r == 0) return 1'b0;
    return ((c + off_t[r]) % per_t[r]) == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctr  = 0;
    m_pend = 1'b0;
    m_rr   = 0;
    m_last = -1;
    n_exe  = 0;
    tick_strobe.delete();
    tick_ctr.delete();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tick", noise_tick, 1'b0);
    chk("rst_ack", env_ack, '0);
    chk("rst_fire", env_fire, 1'b0);
    chk("rst_ctr", glob_ctr, 15'd0);
    env_req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One clk: predict from the model, advance, compare, then act as the requesters.
  task automatic cyc(input bit en, input bit exe);
    logic [V-1:0] e_ack;
    bit           e_tick, e_fire;
    int           w;
    cpu_en    = en;
    exe_32khz = exe;
    e_ack  = '0;
    e_tick = 1'b0;
    e_fire = 1'b0;
    if (en) begin
      if (exe) begin
        m_ctr  = (m_ctr == 0) ? CR - 1 : m_ctr - 1;
        m_pend = 1'b1;
        n_exe++;
      end else if (m_pend) begin
        e_tick = mfire(m_ctr, noise_rate_id);
        m_pend = 1'b0;
        m_last = -1;
      end else begin
        w = -1;
        for (int j = 0; j < V; j++) begin
          int c = (m_rr + j) % V;
          if (w < 0 && env_req[c] && c != m_last) w = c;
        end
        if (w >= 0) begin
          e_ack[w] = 1'b1;
          e_fire   = mfire(m_ctr, env_rate_id[5*w +: 5]);
          m_rr     = (w + 1) % V;
        end
        m_last = w;
      end
    end
    @(posedge clk);
    #1;
    chk("glob_ctr", glob_ctr, m_ctr[14:0]);
    chk("noise_tick", noise_tick, e_tick);
    chk("env_ack", env_ack, e_ack);
    chk("env_fire", env_fire, e_fire);
    if (noise_tick === 1'b1) begin
      tick_cnt++;
      tick_strobe.push_back(n_exe);
      tick_ctr.push_back(m_ctr);
    end
    for (int i = 0; i < V; i++) begin
      if (env_ack[i] === 1'b1) begin
        ack_order.push_back(i);
        ack_fire.push_back(env_fire);
        env_req[i] = 1'b0;
      end else if (rnd_req && !env_req[i] && $urandom_range(3) == 0) begin
        env_rate_id[5*i +: 5] = 5'($urandom_range(31));
        env_req[i] = 1'b1;
      end
    end
  endtask

  initial begin
    tick_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_tick", noise_tick, 1'b0);
    chk("init_ack", env_ack, '0);
    chk("init_ctr", glob_ctr, 15'd0);
    reset = 1'b0;

    cyc(1'b1, 1'b1);
    chk("first_exe_wrap", glob_ctr, 15'd30719);
    cyc(1'b1, 1'b0);

    noise_rate_id = 5'd31;
    t0 = tick_cnt;
    repeat (5) begin cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); end
    chk("rate31_ticks", tick_cnt - t0, 5);
    noise_rate_id = 5'd0;
    t0 = tick_cnt;
    repeat (5) begin cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); end
    chk("rate0_ticks", tick_cnt - t0, 0);

    noise_rate_id = 5'd31;
    cyc(1'b1, 1'b1);
    do_reset();
    cyc(1'b1, 1'b0);

    noise_rate_id = 5'd1;
    do_reset();
    repeat (4100) begin cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); end
    chk("rate1_count", tick_strobe.size(), 2);
    if (tick_strobe.size() >= 2) begin
      chk("rate1_first", tick_strobe[0], 2048);
      chk("rate1_ctr", tick_ctr[0], 28672);
      chk("rate1_second", tick_strobe[1], 4096);
    end

    noise_rate_id = 5'd2;
    do_reset();
    repeat (2600) begin cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); end
    chk("rate2_count", tick_strobe.size(), 2);
    if (tick_strobe.size() >= 2) begin
      chk("rate2_first", tick_strobe[0], 1040);
      chk("rate2_ctr", tick_ctr[0], 29680);
      chk("rate2_second", tick_strobe[1], 2576);
    end

    noise_rate_id = 5'd0;
    do_reset();
    env_rate_id = {(5*V){1'b1}};
    ack_order.delete();
    ack_fire.delete();
    env_req = 8'hFF;
    repeat (10) cyc(1'b1, 1'b0);
    chk("rr_count", ack_order.size(), 8);
    for (int i = 0; i < ack_order.size(); i++) begin
      chk("rr_order", ack_order[i], i);
      chk("rr_fire", ack_fire[i], 1'b1);
    end
    ack_order.delete();
    env_req = 8'h24;
    repeat (4) cyc(1'b1, 1'b0);
    chk("wrap_count", ack_order.size(), 2);
    if (ack_order.size() >= 2) begin
      chk("wrap_first", ack_order[0], 2);
      chk("wrap_second", ack_order[1], 5);
    end

    noise_rate_id = 5'd30;
    do_reset();
    t0 = tick_cnt;
    cyc(1'b1, 1'b1);
    env_req[3] = 1'b1;
    cyc(1'b1, 1'b1);
    chk("dbl_ctr", glob_ctr, 15'd30718);
    cyc(1'b1, 1'b0);
    chk("dbl_tick", noise_tick, 1'b1);
    chk("dbl_no_ack", env_ack, 8'h00);
    cyc(1'b1, 1'b0);
    chk("dbl_ack", env_ack, 8'h08);
    repeat (3) cyc(1'b1, 1'b0);
    chk("dbl_tick_cnt", tick_cnt - t0, 1);

    do_reset();
    rnd_req = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) noise_rate_id = 5'($urandom_range(31));
      cyc($urandom_range(3) != 0, $urandom_range(4) == 0);
    end
    rnd_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_scheduler.md
# rate_scheduler

- Shared DSP rate scheduler; replaces the per-block rate counters.
- Holds the global sample counter (decrements once per 32 kHz sample) and one time-shared rate evaluator.
- The evaluator answers "does rate N fire this sample" for the noise LFSR and for up to eight voice envelope requesters, which are arbitrated round-robin.
- `noise_tick` drives the noise LFSR shift enable directly.

## Interface
Parameters:
- `VOICES`, default 8: number of envelope requesters.
- `CTR_RANGE`, default 30720: counter modulus; the reload value is `CTR_RANGE-1` (0x77FF).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `cpu_en`, in, 1: clock enable; all state changes only on `cpu_en` cycles.
- `exe_32khz`, in, 1: sample strobe, qualified by `cpu_en`.
- `noise_rate_id`, in, 5: noise rate index (0..31).
- `noise_tick`, out, 1: one-clk pulse, asserted when the noise rate fires this sample.
- `env_req`, in, `VOICES`: per-voice evaluation request, level-held until acknowledged.
- `env_rate_id`, in, `5*VOICES`: packed rate index; voice i occupies bits [5i+4:5i]; held stable while `env_req[i]` is high.
- `env_ack`, out, `VOICES`: one-hot, one-clk pulse marking the voice being answered.
- `env_fire`, out, 1: evaluation result; valid only while `env_ack` is non-zero, 0 otherwise.
- `glob_ctr`, out, 15: current counter value (debug / envelope use).

## Operation
**Counter**
- On a `cpu_en & exe_32khz` cycle: `ctr <= (ctr==0) ? CTR_RANGE-1 : ctr-1`.
- The same cycle sets `noise_pend`.

**Rate tables**, indexed by rate_id 0..31:
- Period: ∞ (never), 2048, 1536, 1280, 1024, 768, 640, 512, 384, 320, 256, 192, 160, 128, 96, 80, 64, 48, 40, 32, 24, 20, 16, 12, 10, 8, 6, 5, 4, 3, 2, 1.
- Offset: 0 for ids 0, 1, 4, 7, 10, 13, 16, 19, 22, 25, 28, 30, 31; 1040 for ids 2, 5, 8, 11, 14, 17, 20, 23, 26, 29; 536 for ids 3, 6, 9, 12, 15, 18, 21, 24, 27.

**fire(r)**
- fire(r) = (r != 0) && ((ctr + offset[r]) mod period[r] == 0), evaluated on the counter value at evaluation time.
- `ctr + offset` has a maximum of 31759 and fits in 15 bits.
- Any modulo implementation is allowed (for example, an explicit odd-factor check plus a mask) provided it is bit-exact to this definition for all 30720 × 32 combinations.

**Slot priority per `cpu_en` cycle**, highest first:
1. `exe_32khz` cycle: counter update only; no evaluation.
2. `noise_pend` set: evaluate `noise_rate_id`; register `noise_tick` = fire; clear `noise_pend`.
3. Otherwise: envelope arbitration.

**Envelope arbitration**
- Eligible voices are those with `env_req[i]=1` and not granted on the previous evaluation cycle (the in-flight mask).
- The winner is the first eligible voice scanning upward from `rr_ptr`, wrapping at `VOICES-1` to 0.
- Register `env_ack[i]=1` and `env_fire` = fire(`env_rate_id[i]`); then `rr_ptr <= i+1` (wraps).
- With no eligible voice, no ack is issued and `rr_ptr` is unchanged.
- The requester drops `env_req[i]` in the clk where `env_ack[i]` is seen. A request still high afterwards is served again, which is the requester's responsibility.

**Boundaries**
- Counter wrap: 0 → 30719.
- Second `exe_32khz` before the noise slot: `noise_pend` stays set, noise is evaluated once, on the newer counter value.
- Rate 0 never fires. Rate 31 fires every sample.
- `noise_rate_id` change: takes effect at the next noise slot.

**Reset (async)**
- `ctr=0`, `noise_pend=0`, `rr_ptr=0`, in-flight mask cleared.
- `noise_tick=0`, `env_ack=0`, `env_fire=0`, `glob_ctr=0`.
- Reset mid-request drops the pending grant; no ack is issued.

## Timing
- `glob_ctr` is registered and shows the new value the clk after the `exe_32khz` cycle.
- `noise_tick`:
  - Registered; high for exactly one clk, starting the clk after the noise-slot `cpu_en` cycle.
  - With `cpu_en` held continuously high, it is two clks after `exe_32khz`.
- `env_ack` / `env_fire`: registered, high for exactly one clk after the arbitration `cpu_en` cycle.
- Request-to-ack latency:
  - Minimum one `cpu_en` cycle.
  - Worst case with `cpu_en` continuous: exe cycle + noise slot + (`VOICES`-1) other grants + 1.
- `cpu_en` low: all state frozen; outputs return to 0 after their single pulse clk.

## Test plan
- Async reset pulse mid-sample → all outputs 0 immediately; `glob_ctr=0`. The first exe gives `glob_ctr`=30719.
- `noise_rate_id`=0x1F, 5 exe strobes with `cpu_en`=1 → `noise_tick` pulses 5 times, each two clks after its strobe. `noise_rate_id`=0 → no pulse.
- `noise_rate_id`=0x01 from reset → first `noise_tick` on the 2048th exe strobe (ctr=28672), then every 2048 strobes.
- `noise_rate_id`=0x02 from reset → first tick on the 1040th strobe (ctr=29680; 29680+1040=30720 ≡ 0 mod 1536), then every 1536 strobes.
- `env_req`=0xFF with all rates 0x1F, each voice dropping its request on its ack → acks in order voice 0..7, each with `env_fire`=1. Then voices 5 and 2 re-request → voice 2 is acked before voice 5 (wrap from `rr_ptr`=0).
- `exe_32khz` on consecutive `cpu_en` cycles → `glob_ctr` decrements twice and exactly one `noise_tick` decision is made, on the second value. An `env_req` raised in the exe cycle is acked only after the noise slot.
